// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// -----------------------------------------------------------------------------
// Source-side raster generator. Produces vs/hs/de timing plus 3 x 8-bit pixel
// data with a selectable test pattern (colour bars, ramp, checkerboard, solid).
// Raster order per line and per frame is: sync, back porch, active, front porch.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high (priority over en)
//   en           run enable; low forces the raster to idle (all outputs 0)
//   mode         pattern select: 0 bars, 1 ramp, 2 checker, 3 solid
//   solid_r/g/b  solid colour used by mode 3
//   vs_out       low during vertical sync lines, high otherwise
//   hs_out       low during horizontal sync clocks, high otherwise
//   de_out       active pixel
//   data1_out    pixel channel 1 (R)
//   data2_out    pixel channel 2 (G)
//   data3_out    pixel channel 3 (B)
//   frame_start  one-cycle pulse on the first output cycle of each frame
//
// All outputs are registered: the output in cycle n+1 reflects the counter
// state of cycle n, so timing and data stay mutually aligned.
// H_ACTIVE must be a multiple of 8; H_TOTAL and V_TOTAL must not exceed 4096.
// -----------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 8,
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 4,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4,
  parameter int V_ACTIVE = 48,
  parameter int V_FP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] solid_r,
  input  logic [7:0] solid_g,
  input  logic [7:0] solid_b,
  output logic       vs_out,
  output logic       hs_out,
  output logic       de_out,
  output logic [7:0] data1_out,
  output logic [7:0] data2_out,
  output logic [7:0] data3_out,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_STOP  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_STOP  = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] BAR_W       = 12'(H_ACTIVE / 8);

  // Colour-bar lookup, {R,G,B}. Indices outside 0..7 cannot occur while de is
  // high; they map to black.
  function automatic logic [23:0] bar_colour(input logic [11:0] bar);
    logic [23:0] c;
    case (bar)
      12'd0:   c = 24'hFF_FF_FF;  // white
      12'd1:   c = 24'hFF_FF_00;  // yellow
      12'd2:   c = 24'h00_FF_FF;  // cyan
      12'd3:   c = 24'h00_FF_00;  // green
      12'd4:   c = 24'hFF_00_FF;  // magenta
      12'd5:   c = 24'hFF_00_00;  // red
      12'd6:   c = 24'h00_00_FF;  // blue
      12'd7:   c = 24'h00_00_00;  // black
      default: c = 24'h00_00_00;
    endcase
    return c;
  endfunction

  logic [11:0] h_cnt_r;
  logic [11:0] v_cnt_r;
  logic [1:0]  mode_r;
  logic [23:0] colour_r;

  logic        hs_s;
  logic        vs_s;
  logic        de_s;
  logic        fs_s;
  logic [11:0] x_s;
  logic [11:0] y_s;
  logic [11:0] bar_s;
  logic [1:0]  mode_s;
  logic [23:0] colour_s;
  logic [23:0] pix_s;

  // Raster counters: advance while enabled, held at the origin otherwise so
  // that a restart always begins with a full sync sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
    end else if (!en) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 12'd0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= 12'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 12'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 12'd1;
    end
  end

  // Pattern settings are captured only at the frame origin, so a change made
  // mid-frame shows up on the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r   <= 2'd0;
      colour_r <= 24'h00_00_00;
    end else if (en && fs_s) begin
      mode_r   <= mode;
      colour_r <= {solid_r, solid_g, solid_b};
    end else begin
      mode_r   <= mode_r;
      colour_r <= colour_r;
    end
  end

  // Timing decode and pattern generation from the current counter state.
  always_comb begin
    hs_s     = 1'b0;
    vs_s     = 1'b0;
    de_s     = 1'b0;
    fs_s     = 1'b0;
    x_s      = 12'd0;
    y_s      = 12'd0;
    bar_s    = 12'd0;
    mode_s   = 2'd0;
    colour_s = 24'h00_00_00;
    pix_s    = 24'h00_00_00;

    hs_s = (h_cnt_r >= H_SYNC_END);
    vs_s = (v_cnt_r >= V_SYNC_END);
    de_s = (h_cnt_r >= H_ACT_START) && (h_cnt_r < H_ACT_STOP) &&
           (v_cnt_r >= V_ACT_START) && (v_cnt_r < V_ACT_STOP);
    fs_s = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);

    // Coordinates are only meaningful while de is high.
    x_s   = h_cnt_r - H_ACT_START;
    y_s   = v_cnt_r - V_ACT_START;
    bar_s = x_s / BAR_W;

    // At the frame origin the freshly captured settings apply immediately;
    // this only matters for rasters with zero sync and back porch.
    if (fs_s) begin
      mode_s   = mode;
      colour_s = {solid_r, solid_g, solid_b};
    end else begin
      mode_s   = mode_r;
      colour_s = colour_r;
    end

    if (de_s) begin
      case (mode_s)
        2'd0:    pix_s = bar_colour(bar_s);
        2'd1:    pix_s = {x_s[7:0], x_s[7:0], x_s[7:0]};
        // 8x8 checker cells: bit 3 of x xor bit 3 of y.
        2'd2:    pix_s = (((x_s ^ y_s) & 12'h008) != 12'h000) ? 24'hFF_FF_FF : 24'h00_00_00;
        2'd3:    pix_s = colour_s;
        default: pix_s = 24'h00_00_00;
      endcase
    end else begin
      pix_s = 24'h00_00_00;
    end
  end

  // Output register stage; the idle raster (en low) drives everything to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_out      <= 1'b0;
      hs_out      <= 1'b0;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
      data1_out   <= 8'h00;
      data2_out   <= 8'h00;
      data3_out   <= 8'h00;
    end else if (!en) begin
      vs_out      <= 1'b0;
      hs_out      <= 1'b0;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
      data1_out   <= 8'h00;
      data2_out   <= 8'h00;
      data3_out   <= 8'h00;
    end else begin
      vs_out      <= vs_s;
      hs_out      <= hs_s;
      de_out      <= de_s;
      frame_start <= fs_s;
      data1_out   <= pix_s[23:16];
      data2_out   <= pix_s[15:8];
      data3_out   <= pix_s[7:0];
    end
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Source-side stage that produces the raster timing (vs/hs/de) and 3-channel 8-bit pixel data. Its outputs feed the block-masking stage and the rest of the image-processing chain. The pattern is selectable: colour bars, ramp, checkerboard or solid colour. The block provides a deterministic stimulus for bring-up and for self-checking benches.

Parameters:
H_SYNC, 4, hsync width in clocks
H_BP, 8, horizontal back porch in clocks
H_ACTIVE, 64, active pixels per line; must be a multiple of 8
H_FP, 4, horizontal front porch in clocks
V_SYNC, 2, vsync width in lines
V_BP, 4, vertical back porch in lines
V_ACTIVE, 48, active lines per frame
V_FP, 2, vertical front porch in lines

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-high
en  input  1  run enable
mode  input  2  pattern select: 0 bars, 1 ramp, 2 checker, 3 solid
solid_r  input  8  solid colour, channel 1
solid_g  input  8  solid colour, channel 2
solid_b  input  8  solid colour, channel 3
vs_out  output  1  vertical timing; low during sync lines, high otherwise
hs_out  output  1  horizontal timing; low during sync clocks, high otherwise
de_out  output  1  active pixel
data1_out  output  8  pixel channel 1 (R)
data2_out  output  8  pixel channel 2 (G)
data3_out  output  8  pixel channel 3 (B)
frame_start  output  1  one-cycle pulse aligned with the first output cycle of each frame

Behaviour:
- Interface: one clock, clk. rst is synchronous, active-high.
- Counters: 12-bit h_cnt and v_cnt.
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL is defined likewise. Both must be ≤ 4096.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Line and frame order: sync, back porch, active, front porch.
  - hs = (h_cnt >= H_SYNC).
  - vs = (v_cnt >= V_SYNC).
  - de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Coordinates: x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP), both valid only while de.
- Latency: every output is registered. The output at cycle n+1 reflects counter state at cycle n. vs, hs, de and data are mutually aligned.
- Pattern data while de is high:
  - mode 0, colour bars: bar = x/(H_ACTIVE/8). Bars 0..7 as {R,G,B} = white FF/FF/FF, yellow FF/FF/00, cyan 00/FF/FF, green 00/FF/00, magenta FF/00/FF, red FF/00/00, blue 00/00/FF, black 00/00/00.
  - mode 1, ramp: all channels = x[7:0]; wraps every 256 pixels.
  - mode 2, checker: all channels = (x[3]^y[3]) ? FF : 00.
  - mode 3, solid: channels = the latched solid_r/g/b.
- Blanking: data = 0 whenever de is low.
- Mode and solid colour latching:
  - mode and solid_* are latched only at frame start (h_cnt=0, v_cnt=0 while en).
  - A change mid-frame takes effect at the next frame.
  - On the first frame after reset or en rise, the values present at that cycle are latched.
- frame_start: a 1-cycle pulse on the output cycle reflecting h_cnt=0, v_cnt=0.
- en low:
  - Counters are forced to 0 at the next edge.
  - All outputs are driven 0 (vs=hs=de=0, data=0, frame_start=0); the idle raster is treated as in-sync.
  - en falling mid-frame aborts the frame immediately, with no completion of the current line.
- en rise: counting starts from h=0,v=0 at the first edge where en is sampled high. The first output, including frame_start=1, appears one cycle later.
- Reset: all outputs 0, counters 0, latched mode = 0, latched colour = 0. Reset has priority over en, including mid-frame.
- Boundaries:
  - The last active pixel of the last active line is followed by front-porch blanking with data 0.
  - The h/v wrap at (H_TOTAL-1, V_TOTAL-1) produces a new frame_start on the next output cycle.

Test Plan:
- Reset, then en=1, defaults (H_TOTAL=80, V_TOTAL=56) -> frame_start every 4480 cycles; per frame exactly 3072 de cycles, 48 de rising edges, 2 vs-low lines; hs low for 4 clocks per line.
- en rises at cycle 0 -> frame_start=1 at cycle 1; the first de=1 occurs at cycle 1+6*80+12 = 493.
- mode=0 -> on the first active line, x=0 gives FF/FF/FF, x=8 gives FF/FF/00, x=40 gives FF/00/00, x=63 gives 00/00/00; data=0 at the de-low cycle following x=63.
- mode=2 -> x=0,y=0 gives 00; x=8,y=0 gives FF; x=8,y=8 gives 00. mode=1 -> x=37 gives 25h on all channels.
- mode changes 0→3 with solid=12/34/56 at active line 10 -> the remainder of the frame stays bars; the next frame is all 12/34/56 for all 3072 pixels.
- en dropped mid-line, held low 5 cycles, raised again -> outputs 0 from the next cycle; restart shows frame_start and the full sync sequence. A rst pulse mid-frame gives the same restart behaviour, with latched mode reset to 0.
